// File: rtl/alu_flags_unit_pkg.sv
// Shared constants for the flag unit: flag bit positions, register widths
// and the 4-bit branch condition codes.
package alu_flags_unit_pkg;

    // Flag bit positions inside the flag vector
    localparam int ALU_FLAG_Z   = 0;
    localparam int ALU_FLAG_C   = 1;
    localparam int ALU_FLAG_N   = 2;
    localparam int ALU_FLAG_O   = 3;
    localparam int ALU_FLAG_P   = 4;
    localparam int ALU_FLAG_CNT = 5;

    // Status-register data width
    localparam int RW = 16;

    // Branch condition code width
    localparam int COND_W = 4;

    typedef enum logic [COND_W-1:0] {
        COND_ALWAYS = 4'd0,
        COND_EQ     = 4'd1,
        COND_NE     = 4'd2,
        COND_LTU    = 4'd3,
        COND_GEU    = 4'd4,
        COND_GTU    = 4'd5,
        COND_LEU    = 4'd6,
        COND_LT     = 4'd7,
        COND_GE     = 4'd8,
        COND_GT     = 4'd9,
        COND_LE     = 4'd10,
        COND_MI     = 4'd11,
        COND_OV     = 4'd12,
        COND_PE     = 4'd13,
        COND_CS     = 4'd14,
        COND_NEVER  = 4'd15
    } cond_e;

endpackage

// File: rtl/alu_flags_unit_cond_eval.sv
// cond_eval: combinational branch-condition evaluator. Takes a flag vector
// and a 4-bit condition code and returns whether the condition holds.
// C = 1 means "no borrow" (l >= r unsigned); signed less-than is S = N ^ O.
module cond_eval
#(
    parameter int FLAG_W = alu_flags_unit_pkg::ALU_FLAG_CNT
)
(
    input  logic [FLAG_W-1:0]                      flags,
    input  logic [alu_flags_unit_pkg::COND_W-1:0]  cond,
    output logic                                   cond_true
);
    import alu_flags_unit_pkg::*;

    logic flag_z;
    logic flag_c;
    logic flag_n;
    logic flag_o;
    logic flag_p;
    logic flag_s;

    // Split the vector into named flags and derive the signed-less-than bit
    always_comb begin
        flag_z = flags[ALU_FLAG_Z];
        flag_c = flags[ALU_FLAG_C];
        flag_n = flags[ALU_FLAG_N];
        flag_o = flags[ALU_FLAG_O];
        flag_p = flags[ALU_FLAG_P];
        flag_s = flag_n ^ flag_o;
    end

    // Decode the condition code against the named flags
    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(cond))
            COND_ALWAYS: cond_true = 1'b1;
            COND_EQ:     cond_true = flag_z;
            COND_NE:     cond_true = !flag_z;
            COND_LTU:    cond_true = !flag_c;
            COND_GEU:    cond_true = flag_c;
            COND_GTU:    cond_true = flag_c && !flag_z;
            COND_LEU:    cond_true = !flag_c || flag_z;
            COND_LT:     cond_true = flag_s;
            COND_GE:     cond_true = !flag_s;
            COND_GT:     cond_true = !flag_z && !flag_s;
            COND_LE:     cond_true = flag_z || flag_s;
            COND_MI:     cond_true = flag_n;
            COND_OV:     cond_true = flag_o;
            COND_PE:     cond_true = flag_p;
            COND_CS:     cond_true = flag_c;
            default:     cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_flags_unit.sv
// alu_flags_unit: status-flag register, one-deep interrupt shadow,
// software-visible status register and branch-condition evaluation.
// Optional macro ALU_FLAGS_BYPASS_EN forwards the incoming ALU flags to the
// condition evaluator in the cycle they are written.
module alu_flags_unit
#(
    parameter int RW     = alu_flags_unit_pkg::RW,
    parameter int FLAG_W = alu_flags_unit_pkg::ALU_FLAG_CNT
)
(
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic [FLAG_W-1:0]                      i_flags,
    input  logic                                   i_flags_we,
    input  logic                                   i_stall,
    input  logic                                   i_sr_we,
    input  logic [RW-1:0]                          i_sr_data,
    input  logic                                   i_irq_save,
    input  logic                                   i_irq_restore,
    input  logic [alu_flags_unit_pkg::COND_W-1:0]  i_cond,
    output logic [FLAG_W-1:0]                      o_flags,
    output logic [RW-1:0]                          o_sr,
    output logic                                   o_carry,
    output logic                                   o_cond_true
);
    import alu_flags_unit_pkg::*;

    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] shadow_q;
    logic [FLAG_W-1:0] flags_d;
    logic [FLAG_W-1:0] eff_flags;

    // Next flag value: restore beats software write beats ALU capture
    always_comb begin
        flags_d = flags_q;
        if (i_irq_restore) begin
            flags_d = shadow_q;
        end else if (i_sr_we) begin
            flags_d = i_sr_data[FLAG_W-1:0];
        end else if (i_flags_we) begin
            flags_d = i_flags;
        end
    end

    // Flag and shadow registers; stall freezes both. The shadow takes the
    // pre-edge flags, so save+restore together swaps the two registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            flags_q  <= '0;
            shadow_q <= '0;
        end else if (!i_stall) begin
            flags_q <= flags_d;
            if (i_irq_save) begin
                shadow_q <= flags_q;
            end
        end
    end

    // Effective flags seen by the branch condition
`ifdef ALU_FLAGS_BYPASS_EN
    always_comb begin
        eff_flags = flags_q;
        if (i_flags_we && !i_stall && !i_irq_restore && !i_sr_we) begin
            eff_flags = i_flags;
        end
    end
`else
    always_comb begin
        eff_flags = flags_q;
    end
`endif

    cond_eval #(
        .FLAG_W (FLAG_W)
    ) u_cond_eval (
        .flags     (eff_flags),
        .cond      (i_cond),
        .cond_true (o_cond_true)
    );

    // Registered outputs; carry is never bypassed to keep the ALU loop open
    always_comb begin
        o_flags             = flags_q;
        o_carry             = flags_q[ALU_FLAG_C];
        o_sr                = '0;
        o_sr[FLAG_W-1:0]    = flags_q;
    end

endmodule

// File: tb/tb_alu_flags_unit.sv
// Self-checking bench for alu_flags_unit: directed scenarios followed by
// randomized cycles, checked against a behavioural model of the flag unit.
module tb_alu_flags_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  flags_in;
    logic        flags_we;
    logic        stall;
    logic        sr_we;
    logic [15:0] sr_data;
    logic        irq_save;
    logic        irq_restore;
    logic [3:0]  cond;
    logic [4:0]  flags_out;
    logic [15:0] sr_out;
    logic        carry_out;
    logic        cond_true;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit [4:0] m_flags;
    bit [4:0] m_shadow;

    always #5 clk = ~clk;

    alu_flags_unit #(
        .RW     (16),
        .FLAG_W (5)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_flags       (flags_in),
        .i_flags_we    (flags_we),
        .i_stall       (stall),
        .i_sr_we       (sr_we),
        .i_sr_data     (sr_data),
        .i_irq_save    (irq_save),
        .i_irq_restore (irq_restore),
        .i_cond        (cond),
        .o_flags       (flags_out),
        .o_sr          (sr_out),
        .o_carry       (carry_out),
        .o_cond_true   (cond_true)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Branch truth from flag meanings: Z=0 C=1 N=2 O=3 P=4
    function automatic bit ref_cond(input int code, input bit [4:0] f);
        bit z, c, n, o, p, s;
        z = f[0]; c = f[1]; n = f[2]; o = f[3]; p = f[4];
        s = (n != o);
        case (code)
            0:  return 1'b1;
            1:  return z;
            2:  return !z;
            3:  return !c;
            4:  return c;
            5:  return c && !z;
            6:  return !c || z;
            7:  return s;
            8:  return !s;
            9:  return !z && !s;
            10: return z || s;
            11: return n;
            12: return o;
            13: return p;
            14: return c;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit [4:0] ref_eff();
`ifdef ALU_FLAGS_BYPASS_EN
        if (flags_we && !stall && !irq_restore && !sr_we) return flags_in;
`endif
        return m_flags;
    endfunction

    // One clock: drive inputs, check the combinational condition before the
    // edge, advance the model, then check the registered outputs after it.
    task automatic cycle(input bit fwe, input bit [4:0] f, input bit swe,
                         input bit [15:0] sd, input bit sv, input bit rs,
                         input bit st, input bit [3:0] cc, input string tag);
        bit [4:0] nf;
        flags_we = fwe; flags_in = f; sr_we = swe; sr_data = sd;
        irq_save = sv; irq_restore = rs; stall = st; cond = cc;
        #1;
        check({tag, ".cond"}, 32'(cond_true), 32'(ref_cond(int'(cc), ref_eff())));
        @(posedge clk);
        if (!st) begin
            nf = m_flags;
            if (rs)       nf = m_shadow;
            else if (swe) nf = sd[4:0];
            else if (fwe) nf = f;
            if (sv) m_shadow = m_flags;
            m_flags = nf;
        end
        #1;
        check({tag, ".flags"}, 32'(flags_out), 32'(m_flags));
        check({tag, ".sr"},    32'(sr_out),    {27'd0, m_flags});
        check({tag, ".carry"}, 32'(carry_out), 32'(m_flags[1]));
    endtask

    task automatic idle(input bit [3:0] cc, input string tag);
        cycle(1'b0, 5'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, cc, tag);
    endtask

    initial begin
        rst_n = 1'b0;
        flags_in = '0; flags_we = 1'b0; stall = 1'b0; sr_we = 1'b0;
        sr_data = '0; irq_save = 1'b0; irq_restore = 1'b0; cond = 4'd4;
        m_flags = '0; m_shadow = '0;
        #12;
        check("rst.flags", 32'(flags_out), 32'd0);
        check("rst.sr",    32'(sr_out),    32'd0);
        check("rst.carry", 32'(carry_out), 32'd0);
        check("rst.geu",   32'(cond_true), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Compare result Z=1 C=1 with EQ in the same cycle, then the next
        cycle(1'b1, 5'b00011, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 4'd1, "cmp_eq");
        idle(4'd1, "eq_next");
        check("eq_next.lit", 32'(cond_true), 32'd1);

        // Software write wins over ALU capture; stalled write is dropped
        cycle(1'b1, 5'b11000, 1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 4'd0, "sr_prio");
        check("sr_prio.lit", 32'(flags_out), 32'b00100);
        cycle(1'b1, 5'b11111, 1'b1, 16'h001f, 1'b0, 1'b0, 1'b1, 4'd15, "stall");
        check("stall.lit", 32'(flags_out), 32'b00100);

        // Signed compares with N=1 O=1 Z=0
        cycle(1'b1, 5'b01100, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 4'd0, "nz_o");
        idle(4'd7, "lt_no");
        check("lt_no.lit", 32'(cond_true), 32'd0);
        idle(4'd8,  "ge_no");
        check("ge_no.lit", 32'(cond_true), 32'd1);
        idle(4'd9,  "gt_no");
        check("gt_no.lit", 32'(cond_true), 32'd1);
        idle(4'd10, "le_no");
        check("le_no.lit", 32'(cond_true), 32'd0);
        cycle(1'b1, 5'b00100, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 4'd0, "n_only");
        idle(4'd7, "lt_n");
        check("lt_n.lit", 32'(cond_true), 32'd1);

        // Interrupt shadow: save with simultaneous write, restore, swap
        cycle(1'b1, 5'b10101, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 4'd0, "pre_save");
        cycle(1'b1, 5'b00010, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 4'd0, "save_we");
        check("save_we.lit", 32'(flags_out), 32'b00010);
        cycle(1'b0, 5'd0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 4'd0, "restore");
        check("restore.lit", 32'(flags_out), 32'b10101);
        cycle(1'b1, 5'b01010, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 4'd0, "pre_swap");
        cycle(1'b0, 5'd0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 4'd0, "swap");
        check("swap.lit", 32'(flags_out), 32'b10101);
        cycle(1'b0, 5'd0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 4'd0, "swap_back");
        check("swap_back.lit", 32'(flags_out), 32'b01010);

        // Asynchronous reset mid-sequence
        cycle(1'b1, 5'b11111, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 4'd0, "pre_rst");
        rst_n = 1'b0;
        #1;
        check("arst.flags", 32'(flags_out), 32'd0);
        check("arst.sr",    32'(sr_out),    32'd0);
        m_flags = '0; m_shadow = '0;
        rst_n = 1'b1;
        cycle(1'b0, 5'd0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 4'd0, "rst_restore");
        check("rst_restore.lit", 32'(flags_out), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom),
                  ($urandom_range(0, 5) == 0), 16'($urandom),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 4) == 0), 4'($urandom), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
